// File: rtl/alu_pkg.sv
// Shared opcodes, compare codes and operation-class encoding for the 16-bit ALU.
// The core and the top-level register stage both import this package.
package alu_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [DATA_W-1:0] CMP_EQ = 16'd1;
  localparam logic [DATA_W-1:0] CMP_GT = 16'd2;
  localparam logic [DATA_W-1:0] CMP_LT = 16'd3;

  // One-hot operation class; all-zero means NOP.
  typedef struct packed {
    logic is_arith;
    logic is_logic;
    logic is_cmp;
    logic is_shift;
  } op_class_t;

  localparam op_class_t CLASS_NONE  = 4'b0000;
  localparam op_class_t CLASS_ARITH = 4'b1000;
  localparam op_class_t CLASS_LOGIC = 4'b0100;
  localparam op_class_t CLASS_CMP   = 4'b0010;
  localparam op_class_t CLASS_SHIFT = 4'b0001;

  function automatic logic [DATA_W-1:0] cmp_result(input logic hit, input logic [DATA_W-1:0] code);
    logic [DATA_W-1:0] res;
    if (hit) begin
      res = code;
    end else begin
      res = 16'h0000;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_16b_core.sv
// Purely combinational ALU datapath: decodes ALU_FUN into result, carry and class.
// Unknown selects fall to the default arm and produce an all-zero NOP.
module alu_16b_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_fun,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output op_class_t         op_class
);

  logic [DATA_W:0]     sum_s;
  logic [DATA_W:0]     diff_s;
  logic [2*DATA_W-1:0] product_s;
  logic [DATA_W-1:0]   quot_s;

  assign sum_s     = {1'b0, a} + {1'b0, b};
  assign diff_s    = {1'b0, a} - {1'b0, b};
  assign product_s = {16'h0000, a} * {16'h0000, b};
  // Divide-by-zero is defined to yield zero rather than all-ones.
  assign quot_s    = (b == 16'h0000) ? 16'h0000 : (a / b);

  // Opcode decode into next result, carry and one-hot class.
  always_comb begin
    result   = 16'h0000;
    carry    = 1'b0;
    op_class = CLASS_NONE;
    case (alu_fun)
      OP_ADD: begin
        result   = sum_s[DATA_W-1:0];
        carry    = sum_s[DATA_W];
        op_class = CLASS_ARITH;
      end
      OP_SUB: begin
        result   = diff_s[DATA_W-1:0];
        carry    = diff_s[DATA_W];
        op_class = CLASS_ARITH;
      end
      OP_MUL: begin
        result   = product_s[DATA_W-1:0];
        carry    = |product_s[2*DATA_W-1:DATA_W];
        op_class = CLASS_ARITH;
      end
      OP_DIV: begin
        result   = quot_s;
        op_class = CLASS_ARITH;
      end
      OP_AND: begin
        result   = a & b;
        op_class = CLASS_LOGIC;
      end
      OP_OR: begin
        result   = a | b;
        op_class = CLASS_LOGIC;
      end
      OP_NAND: begin
        result   = ~(a & b);
        op_class = CLASS_LOGIC;
      end
      OP_NOR: begin
        result   = ~(a | b);
        op_class = CLASS_LOGIC;
      end
      OP_XOR: begin
        result   = a ^ b;
        op_class = CLASS_LOGIC;
      end
      OP_XNOR: begin
        result   = ~(a ^ b);
        op_class = CLASS_LOGIC;
      end
      OP_EQ: begin
        result   = cmp_result(a == b, CMP_EQ);
        op_class = CLASS_CMP;
      end
      OP_GT: begin
        result   = cmp_result(a > b, CMP_GT);
        op_class = CLASS_CMP;
      end
      OP_LT: begin
        result   = cmp_result(a < b, CMP_LT);
        op_class = CLASS_CMP;
      end
      OP_SHR: begin
        result   = {1'b0, a[DATA_W-1:1]};
        op_class = CLASS_SHIFT;
      end
      OP_SHL: begin
        result   = {a[DATA_W-2:0], 1'b0};
        op_class = CLASS_SHIFT;
      end
      default: begin
        result   = 16'h0000;
        carry    = 1'b0;
        op_class = CLASS_NONE;
      end
    endcase
  end

endmodule

// File: rtl/alu_16b.sv
// Registered 16-bit ALU: combinational core followed by one output register stage.
// Synchronous active-low reset clears the result and every flag.
module alu_16b
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_FUN,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic              carry_flag,
  output logic              arith_flag,
  output logic              logic_flag,
  output logic              cmp_flag,
  output logic              shift_flag
);

  logic [DATA_W-1:0] core_result_s;
  logic              core_carry_s;
  op_class_t         core_class_s;

  logic [DATA_W-1:0] result_d, result_q;
  logic              carry_d, carry_q;
  op_class_t         class_d, class_q;

  alu_16b_core u_core (
    .a        (A),
    .b        (B),
    .alu_fun  (ALU_FUN),
    .result   (core_result_s),
    .carry    (core_carry_s),
    .op_class (core_class_s)
  );

  // Next-state values for the output register.
  always_comb begin
    result_d = core_result_s;
    carry_d  = core_carry_s;
    class_d  = core_class_s;
  end

  // Output register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      class_q  <= CLASS_NONE;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      class_q  <= class_d;
    end
  end

  assign ALU_OUT    = result_q;
  assign carry_flag = carry_q;
  assign arith_flag = class_q.is_arith;
  assign logic_flag = class_q.is_logic;
  assign cmp_flag   = class_q.is_cmp;
  assign shift_flag = class_q.is_shift;

endmodule

// File: tb/tb_alu_16b.sv
// Scoreboard bench for alu_16b: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares the registered outputs.
module tb_alu_16b;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  fun_in;
  logic [15:0] alu_out;
  logic        carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic [3:0]  cls;   // {arith, logic, cmp, shift}
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_ARITH = 4'b1000;
  localparam logic [3:0] C_LOGIC = 4'b0100;
  localparam logic [3:0] C_CMP   = 4'b0010;
  localparam logic [3:0] C_SHIFT = 4'b0001;

  alu_16b dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a_in),
    .B          (b_in),
    .ALU_FUN    (fun_in),
    .ALU_OUT    (alu_out),
    .carry_flag (carry_flag),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation for one cycle and queue its expected response.
  task automatic issue(input string nm, input logic rst, input logic [3:0] f,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic [3:0] ecls);
    exp_t e;
    rst_n  = rst;
    fun_in = f;
    a_in   = a;
    b_in   = b;
    e.result = er;
    e.carry  = ec;
    e.cls    = ecls;
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: one registered result per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t  e;
    exp_t  got;
    string nm;
    #1;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      got.result = alu_out;
      got.carry  = carry_flag;
      got.cls    = {arith_flag, logic_flag, cmp_flag, shift_flag};
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL %s: got out=%h carry=%b cls=%b, expected out=%h carry=%b cls=%b",
                 nm, got.result, got.carry, got.cls, e.result, e.carry, e.cls);
      end
    end
  end

  initial begin
    a_in = 16'h0000;
    b_in = 16'h0000;
    fun_in = 4'bxxxx;
    rst_n = 1'b0;
    // Reset with an unknown select, then an explicit NOP with live operands.
    issue("reset_x",   1'b0, 4'bxxxx, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, C_NONE);
    issue("reset_add", 1'b0, 4'h0,    16'hFFFF, 16'h0001, 16'h0000, 1'b0, C_NONE);
    issue("nop",       1'b1, 4'hF,    16'h1234, 16'h5678, 16'h0000, 1'b0, C_NONE);
    issue("add_small", 1'b1, 4'h0, 16'd5970,  16'd2940,  16'h22CE, 1'b0, C_ARITH);
    issue("add_carry", 1'b1, 4'h0, 16'd55122, 16'd35708, 16'h62CE, 1'b1, C_ARITH);
    issue("add_wrap",  1'b1, 4'h0, 16'hFFFF,  16'h0001,  16'h0000, 1'b1, C_ARITH);
    issue("sub_borrow",1'b1, 4'h1, 16'd4660,  16'd22136, 16'hBBBC, 1'b1, C_ARITH);
    issue("sub_pos",   1'b1, 4'h1, 16'd55122, 16'd35708, 16'h4BD6, 1'b0, C_ARITH);
    issue("sub_equal", 1'b1, 4'h1, 16'h1234,  16'h1234,  16'h0000, 1'b0, C_ARITH);
    issue("mul",       1'b1, 4'h2, 16'd5,     16'd100,   16'h01F4, 1'b0, C_ARITH);
    issue("mul_ovf",   1'b1, 4'h2, 16'h0100,  16'h0100,  16'h0000, 1'b1, C_ARITH);
    issue("div",       1'b1, 4'h3, 16'd100,   16'd50,    16'h0002, 1'b0, C_ARITH);
    issue("div_zero",  1'b1, 4'h3, 16'd100,   16'd0,     16'h0000, 1'b0, C_ARITH);
    issue("and",       1'b1, 4'h4, 16'h0064, 16'h0032, 16'h0020, 1'b0, C_LOGIC);
    issue("or",        1'b1, 4'h5, 16'h0064, 16'h0032, 16'h0076, 1'b0, C_LOGIC);
    issue("nand",      1'b1, 4'h6, 16'h0064, 16'h0032, 16'hFFDF, 1'b0, C_LOGIC);
    issue("nor",       1'b1, 4'h7, 16'h0064, 16'h0032, 16'hFF89, 1'b0, C_LOGIC);
    issue("xor",       1'b1, 4'h8, 16'h0064, 16'h0032, 16'h0056, 1'b0, C_LOGIC);
    issue("xnor",      1'b1, 4'h9, 16'h0064, 16'h0032, 16'hFFA9, 1'b0, C_LOGIC);
    issue("eq_ne",     1'b1, 4'hA, 16'h0064, 16'h0032, 16'h0000, 1'b0, C_CMP);
    issue("eq_eq",     1'b1, 4'hA, 16'h0032, 16'h0032, 16'h0001, 1'b0, C_CMP);
    issue("gt_true",   1'b1, 4'hB, 16'h0232, 16'h0032, 16'h0002, 1'b0, C_CMP);
    issue("gt_false",  1'b1, 4'hB, 16'h0232, 16'h2032, 16'h0000, 1'b0, C_CMP);
    issue("lt_true",   1'b1, 4'hC, 16'h0232, 16'h2032, 16'h0003, 1'b0, C_CMP);
    issue("lt_equal",  1'b1, 4'hC, 16'h0032, 16'h0032, 16'h0000, 1'b0, C_CMP);
    issue("shr",       1'b1, 4'hD, 16'h0232, 16'hFFFF, 16'h0119, 1'b0, C_SHIFT);
    issue("shl",       1'b1, 4'hE, 16'h0232, 16'hFFFF, 16'h0464, 1'b0, C_SHIFT);
    issue("shr_msb",   1'b1, 4'hD, 16'h8001, 16'h0000, 16'h4000, 1'b0, C_SHIFT);
    issue("shl_msb",   1'b1, 4'hE, 16'h8001, 16'h0000, 16'h0002, 1'b0, C_SHIFT);
    issue("add_pre",   1'b1, 4'h0, 16'd55122, 16'd35708, 16'h62CE, 1'b1, C_ARITH);
    // Mid-stream reset overrides the operation, then the next edge computes normally.
    issue("mid_reset", 1'b0, 4'h0, 16'd55122, 16'd35708, 16'h0000, 1'b0, C_NONE);
    issue("post_reset",1'b1, 4'hB, 16'h0232, 16'h0032, 16'h0002, 1'b0, C_CMP);
    issue("nop_end",   1'b1, 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, C_NONE);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_16b.md
# alu_16b

Unsigned 16-bit registered ALU with a 4-bit function select. It covers add, subtract, multiply, divide, six bitwise logic ops, three compares and single-bit shifts. Each cycle it registers a 16-bit result plus one carry flag and four one-hot operation-class flags. It is a leaf datapath block for the diploma system, driven directly by a controller that supplies operands and opcode every cycle.

## Interface
- No parameters; width fixed at 16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- A  input  16  operand A, unsigned.
- B  input  16  operand B, unsigned.
- ALU_FUN  input  4  operation select.
- ALU_OUT  output  16  registered result.
- carry_flag  output  1  registered carry/borrow.
- arith_flag  output  1  registered; set for arithmetic ops.
- logic_flag  output  1  registered; set for logic ops.
- cmp_flag  output  1  registered; set for compare ops.
- shift_flag  output  1  registered; set for shift ops.

## Operation
- 0000 ADD: ALU_OUT = (A+B)[15:0]; carry = bit 16 of the sum; arith = 1.
- 0001 SUB: ALU_OUT = (A−B) mod 2^16; carry = 1 when A < B (borrow); arith = 1.
- 0010 MUL: ALU_OUT = (A*B)[15:0]; carry = OR of product bits [31:16]; arith = 1.
- 0011 DIV: ALU_OUT = floor(A/B); B = 0 gives ALU_OUT = 0; carry = 0; arith = 1.
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR: bitwise on A and B; carry = 0; logic = 1.
- 1010 EQ: ALU_OUT = 1 if A == B, else 0; cmp = 1.
- 1011 GT: ALU_OUT = 2 if A > B, else 0; cmp = 1.
- 1100 LT: ALU_OUT = 3 if A < B, else 0; cmp = 1.
- 1101 SHR: ALU_OUT = A >> 1, MSB zero-filled; shift = 1. B is ignored.
- 1110 SHL: ALU_OUT = A << 1, LSB zero-filled, bit 15 discarded; shift = 1. B is ignored.
- 1111, and any unknown or X/Z select: NOP. ALU_OUT = 0 and all five flags = 0.
- Class flags are mutually exclusive: exactly one is high for codes 0000–1110, none for NOP.
- carry_flag is 0 for every non-arithmetic op.
- All comparisons and arithmetic are unsigned.

## Timing
- All six outputs are registered on the rising edge of clk.
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- There is no handshake and no stall; a new operation can be issued every cycle.
- Reset: rst_n sampled low at an edge forces ALU_OUT = 0 and all flags = 0. Reset wins over any operation.
- The first edge after rst_n returns high computes from the current inputs.
- Before the first edge, output values are unspecified (no power-on guarantee beyond reset).
- Wrap-around: ADD/SUB/MUL truncate to 16 bits; overflow is reported only through carry_flag as defined above.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams (OP_ADD … OP_SHL, OP_NOP = 4'hF);
  - the compare result constants (EQ = 1, GT = 2, LT = 3).
- One combinational always block computes next-result, next-carry and next-class.
- One sequential always block handles synchronous reset and registering.
- A natural sub-module is alu_16b_core: purely combinational, taking A, B and ALU_FUN and producing the result and flags. The top level only adds the output registers.

## Test plan
- Reset, then X on ALU_FUN → ALU_OUT = 0x0000, all flags 0.
- ADD:
  - A = 5970, B = 2940 → 0x22CE, carry 0, arith 1.
  - A = 55122, B = 35708 → 0x62CE, carry 1, arith 1.
- SUB:
  - A = 4660, B = 22136 → 0xBBBC, carry 1.
  - A = 55122, B = 35708 → 0x4BD6, carry 0.
- MUL 5 × 100 → 0x01F4, carry 0. DIV 100 / 50 → 0x0002. DIV by 0 → 0x0000. Each with arith 1.
- Logic ops, A = 0x0064, B = 0x0032, logic 1 for each:
  - AND → 0x0020, OR → 0x0076, NAND → 0xFFDF;
  - NOR → 0xFF89, XOR → 0x0056, XNOR → 0xFFA9.
- Compare and shift, 1-cycle latency each:
  - EQ 0x0064 vs 0x0032 → 0. EQ 0x0032 vs 0x0032 → 1.
  - GT 0x0232 vs 0x0032 → 2. GT 0x0232 vs 0x2032 → 0.
  - LT 0x0232 vs 0x2032 → 3. Each compare sets cmp 1.
  - SHR 0x0232 → 0x0119; SHL 0x0232 → 0x0464; shift 1.
  - Assert rst_n low mid-stream → outputs 0 on the next edge.
